uc_multiciclo: RTL

//  Multi-cycle RISC-V control FSM: sequences shared ALU/memory/register-file datapath (lw, sw, R, I-ALU, beq, jal).

---
 rtl/uc_multiciclo.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uc_multiciclo.sv
// -----------------------------------------------------------------------------
// uc_multiciclo -- multi-cycle RISC-V control unit
//
// Purpose: sequences a shared ALU / memory / register-file datapath through
// lw, sw, R-type, I-type ALU, beq and jal.
// op/f3/f7 come from the instruction register. zero comes from the ALU.
// Every memory wait (FETCH, MEMREAD, MEMWRITE) is bounded by a timeout
// counter. A timeout raises bus_err and returns the FSM to FETCH.
//
// Parameter:
//   MEM_TIMEOUT  wait cycles allowed per memory access (0 = wait forever)
//
// Optional feature (compile-time macro UCM_BNE_EN):
//   When defined, op=99 with f3=001 is treated as bne (taken = ~zero).
//   When undefined, f3 is ignored in BEQ and taken = zero.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op, f3, f7        instruction fields from IR (only f7[5] is used)
//   zero              ALU zero flag
//   mem_ready         memory access completes this cycle
//   pcWrite, irWrite  PC and IR/oldPC enables
//   memWrite          data memory write enable
//   regWrite          register file write enable
//   adrSrc            memory address select (0=PC, 1=ALUOut)
//   resultSrc         00=ALUOut 01=Data 10=ALU result
//   aluSrcA           00=PC 01=oldPC 10=rs1
//   aluSrcB           00=rs2 01=imm 10=const 4
//   immSrc            00=I 01=S 10=B 11=J (combinational from op)
//   aluControl        000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal_op        pulse: unsupported opcode seen in DECODE
//   bus_err           pulse: memory access timed out
//   state             current state (debug)
// -----------------------------------------------------------------------------
module uc_multiciclo #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic       regWrite,
  output logic [2:0] aluControl,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_VAL = CW'(MEM_TIMEOUT);

  // ALU operation for R-type and I-type ALU instructions.
  // Subtract only applies to R-type (op[5]=1) with f7[5]=1; addi is never sub.
  function automatic logic [2:0] funct_ctrl(input logic [6:0] op_v,
                                            input logic [2:0] f3_v,
                                            input logic       f7b5_v);
    logic [2:0] ctl;
    case (f3_v)
      3'b000:  ctl = (op_v[5] && f7b5_v) ? 3'b001 : 3'b000;
      3'b010:  ctl = 3'b101;
      3'b110:  ctl = 3'b011;
      3'b111:  ctl = 3'b010;
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  // State that DECODE branches to for a given opcode.
  // An unsupported opcode returns FETCH.
  function automatic state_e decode_target(input logic [6:0] op_v);
    state_e nxt;
    case (op_v)
      7'd3, 7'd35: nxt = S_MEMADR;
      7'd51:       nxt = S_EXECR;
      7'd19:       nxt = S_EXECI;
      7'd99:       nxt = S_BEQ;
      7'd111:      nxt = S_JAL;
      default:     nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           adrsrc_q, adrsrc_d;
  logic [1:0]     resultsrc_q, resultsrc_d;
  logic [1:0]     alusrca_q, alusrca_d;
  logic [1:0]     alusrcb_q, alusrcb_d;
  logic [2:0]     alucontrol_q, alucontrol_d;
  logic           memwrite_q, memwrite_d;
  logic           regwrite_q, regwrite_d;

  logic           wait_s;
  logic           timeout_s;
  logic           taken_s;
  logic           legal_s;
  logic           unused_s;

  assign unused_s = ^{f7[6], f7[4:0]};

  assign wait_s    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // mem_ready on the timeout cycle wins, so the timeout requires it low.
  assign timeout_s = (MEM_TIMEOUT > 0) && wait_s && !mem_ready && (cnt_q == TMO_VAL);
  assign legal_s   = (decode_target(op) != S_FETCH);

`ifdef UCM_BNE_EN
  assign taken_s = (f3 == 3'b001) ? !zero : zero;
`else
  assign taken_s = zero;
`endif

  // Next state and wait counter.
  // The counter restarts on every state change, including the timeout self-loop in FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (timeout_s)      state_d = S_FETCH;
        else if (mem_ready) state_d = S_DECODE;
        else                state_d = S_FETCH;
      end
      S_DECODE:  state_d = decode_target(op);
      S_MEMADR:  state_d = (op == 7'd3) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready)      state_d = S_MEMWB;
        else if (timeout_s) state_d = S_FETCH;
        else                state_d = S_MEMREAD;
      end
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready || timeout_s) state_d = S_FETCH;
        else                        state_d = S_MEMWRITE;
      end
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BEQ:     state_d = S_FETCH;
      S_JAL:     state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase

    if ((state_d != state_q) || timeout_s) begin
      cnt_d = '0;
    end else if (wait_s && !mem_ready && (MEM_TIMEOUT > 0)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Mux and enable values for the state being entered.
  // These values are registered so that they line up with state_q.
  always_comb begin
    adrsrc_d     = 1'b0;
    resultsrc_d  = 2'b00;
    alusrca_d    = 2'b00;
    alusrcb_d    = 2'b00;
    alucontrol_d = 3'b000;
    memwrite_d   = 1'b0;
    regwrite_d   = 1'b0;
    case (state_d)
      S_FETCH:    begin alusrcb_d = 2'b10; resultsrc_d = 2'b10; end
      S_DECODE:   begin alusrca_d = 2'b01; alusrcb_d = 2'b01; end
      S_MEMADR:   begin alusrca_d = 2'b10; alusrcb_d = 2'b01; end
      S_MEMREAD:  begin adrsrc_d = 1'b1; end
      S_MEMWB:    begin resultsrc_d = 2'b01; regwrite_d = 1'b1; end
      S_MEMWRITE: begin adrsrc_d = 1'b1; memwrite_d = 1'b1; end
      S_EXECR:    begin alusrca_d = 2'b10; alucontrol_d = funct_ctrl(op, f3, f7[5]); end
      S_EXECI:    begin alusrca_d = 2'b10; alusrcb_d = 2'b01; alucontrol_d = funct_ctrl(op, f3, f7[5]); end
      S_ALUWB:    begin regwrite_d = 1'b1; end
      S_BEQ:      begin alusrca_d = 2'b10; alucontrol_d = 3'b001; end
      S_JAL:      begin alusrca_d = 2'b01; alusrcb_d = 2'b10; end
      default:    begin alusrcb_d = 2'b10; resultsrc_d = 2'b10; end
    endcase
  end

  // State, wait counter and registered datapath controls.
  // Reset loads the FETCH encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      cnt_q        <= '0;
      adrsrc_q     <= 1'b0;
      resultsrc_q  <= 2'b10;
      alusrca_q    <= 2'b00;
      alusrcb_q    <= 2'b10;
      alucontrol_q <= 3'b000;
      memwrite_q   <= 1'b0;
      regwrite_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      adrsrc_q     <= adrsrc_d;
      resultsrc_q  <= resultsrc_d;
      alusrca_q    <= alusrca_d;
      alusrcb_q    <= alusrcb_d;
      alucontrol_q <= alucontrol_d;
      memwrite_q   <= memwrite_d;
      regwrite_q   <= regwrite_d;
    end
  end

  // Immediate format selection, decoded directly from the opcode.
  always_comb begin
    case (op)
      7'd35:   immSrc = 2'b01;
      7'd99:   immSrc = 2'b10;
      7'd111:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  // The strobes depend on mem_ready or zero within the current cycle.
  // They are gated by rst_n so that nothing writes while reset is held.
  assign irWrite    = rst_n & (state_q == S_FETCH) & mem_ready;
  assign pcWrite    = rst_n & (((state_q == S_FETCH) & mem_ready) |
                               ((state_q == S_BEQ) & taken_s) |
                               (state_q == S_JAL));
  assign memWrite   = rst_n & memwrite_q & !timeout_s;
  assign regWrite   = rst_n & regwrite_q;
  assign illegal_op = rst_n & (state_q == S_DECODE) & !legal_s;
  assign bus_err    = rst_n & timeout_s;

  assign adrSrc     = adrsrc_q;
  assign resultSrc  = resultsrc_q;
  assign aluSrcA    = alusrca_q;
  assign aluSrcB    = alusrcb_q;
  assign aluControl = alucontrol_q;
  assign state      = state_q;

endmodule
